fp_add_prealign: RTL

//  Front end of the single-precision FP adder; sits directly downstream of the addpkg unpack types.

---
 rtl/fp_add_prealign_pkg.sv | 43 ++++
 rtl/fp_sticky_shr.sv | 19 +
 rtl/fp_add_prealign.sv | 109 ++++++++++
 3 files changed

// File: rtl/fp_add_prealign_pkg.sv
// Shared types for the single-precision adder front end: IEEE unpack view,
// operand classes and the pre-align stage-1 register layout.
package fp_add_prealign_pkg;

  localparam int SP_EXP_W  = 8;
  localparam int SP_FRAC_W = 23;
  localparam int EXP_BIAS  = 127;
  localparam int SIG_W     = SP_FRAC_W + 1;
  localparam int ALIGN_W   = SIG_W + 3;

  typedef struct packed {
    logic                 sign;
    logic [SP_EXP_W-1:0]  exp;
    logic [SP_FRAC_W-1:0] frac;
  } ieee754_sp_t;

  typedef enum logic [2:0] {FP_ZERO, FP_SUB, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  typedef struct packed {
    logic                res_sign;
    logic                eff_sub;
    logic                is_nan;
    logic                is_inf;
    logic                is_zero;
    logic [SP_EXP_W-1:0] big_exp;
    logic [SP_EXP_W-1:0] d;
    logic [SIG_W-1:0]    big_sig;
    logic [SIG_W-1:0]    small_sig;
  } prealign_s1_t;

  // All-ones exponent equals 2*bias+1 for IEEE binary formats.
  function automatic fp_class_t fp_classify(ieee754_sp_t x);
    fp_class_t c;
    if (x.exp == '0)
      c = (x.frac == '0) ? FP_ZERO : FP_SUB;
    else if (x.exp == SP_EXP_W'(2*EXP_BIAS+1))
      c = (x.frac == '0) ? FP_INF : FP_NAN;
    else
      c = FP_NORM;
    return c;
  endfunction

endpackage

// File: rtl/fp_sticky_shr.sv
// Combinational logical right shift that folds every shifted-out bit into the LSB.
// Shift amounts at or beyond the width collapse to {0..., |din}.
module fp_sticky_shr #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] sh,
  output logic [W-1:0]    dout
);

  logic [W-1:0] kept;
  logic [W-1:0] lost_mask;

  assign kept      = din >> sh;
  assign lost_mask = ~({W{1'b1}} << sh);
  assign dout      = {kept[W-1:1], kept[0] | (|(din & lost_mask))};

endmodule

// File: rtl/fp_add_prealign.sv
// FP add front end: unpack, classify, magnitude swap (stage 1), then align the
// smaller significand with guard/round/sticky (stage 2). Valid/ready, 2-cycle latency.
module fp_add_prealign
  import fp_add_prealign_pkg::*;
#(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int SW     = FRAC_W + 1,
  localparam int AW     = SW + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] big_exp,
  output logic [SW-1:0]    big_sig,
  output logic [AW-1:0]    small_sig,
  output logic             res_sign,
  output logic             eff_sub,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero
);

  ieee754_sp_t  a, b, big, sml;
  fp_class_t    ca, cb;
  logic         swap;
  logic [SP_EXP_W-1:0] big_e, sml_e;
  prealign_s1_t s1, s1_d;
  logic         v1, v2, adv2, acc;
  logic [AW-1:0] small_aligned;

  assign a        = in_a;
  assign b        = in_b;
  assign adv2     = !v2 | out_ready;
  assign in_ready = !v1 | adv2;
  assign acc      = in_valid & in_ready;
  assign out_valid = v2;

  // Ties keep a as the big operand so equal magnitudes take a's sign.
  always_comb begin
    ca    = fp_classify(a);
    cb    = fp_classify(b);
    swap  = {b.exp, b.frac} > {a.exp, a.frac};
    big   = swap ? b : a;
    sml   = swap ? a : b;
    big_e = (big.exp == '0) ? SP_EXP_W'(1) : big.exp;
    sml_e = (sml.exp == '0) ? SP_EXP_W'(1) : sml.exp;
    s1_d           = '0;
    s1_d.big_exp   = big_e;
    s1_d.d         = big_e - sml_e;
    s1_d.big_sig   = {big.exp != '0, big.frac};
    s1_d.small_sig = {sml.exp != '0, sml.frac};
    s1_d.eff_sub   = a.sign ^ b.sign ^ in_sub;
    s1_d.res_sign  = swap ? (b.sign ^ in_sub) : a.sign;
    s1_d.is_nan    = (ca == FP_NAN) | (cb == FP_NAN) |
                     ((ca == FP_INF) & (cb == FP_INF) & s1_d.eff_sub);
    s1_d.is_inf    = ((ca == FP_INF) | (cb == FP_INF)) & !s1_d.is_nan;
    s1_d.is_zero   = (ca == FP_ZERO) & (cb == FP_ZERO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (acc)      s1 <= s1_d;
    end
  end

  fp_sticky_shr #(.W(AW), .SH_W(SP_EXP_W)) u_shr (
    .din  ({s1.small_sig, 3'b000}),
    .sh   (s1.d),
    .dout (small_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      big_exp   <= '0;
      big_sig   <= '0;
      small_sig <= '0;
      res_sign  <= 1'b0;
      eff_sub   <= 1'b0;
      is_nan    <= 1'b0;
      is_inf    <= 1'b0;
      is_zero   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        big_exp   <= s1.big_exp;
        big_sig   <= s1.big_sig;
        small_sig <= small_aligned;
        res_sign  <= s1.res_sign;
        eff_sub   <= s1.eff_sub;
        is_nan    <= s1.is_nan;
        is_inf    <= s1.is_inf;
        is_zero   <= s1.is_zero;
      end
    end
  end

endmodule
